// File: rtl/memory_access.sv
// memory_access: MEM pipeline stage with req/ack data port; `MEM_MISALIGN_TRAP_EN adds the misalignment trap outputs
module memory_access #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_e,
    input  logic            rd_write_e,
    input  logic [1:0]      rd_write_src_e,
    input  logic [4:0]      rd_e,
    input  logic [XLEN-1:0] pc_e,
    input  logic [XLEN-1:0] alu_res_e,
    input  logic [XLEN-1:0] store_data_e,
    input  logic [XLEN-1:0] csr_data_e,
    input  logic            mem_read_e,
    input  logic            mem_write_e,
    input  logic [1:0]      mem_size_e,
    input  logic            mem_unsigned_e,
    output logic            stall_m,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic            misalign_m,
    output logic [XLEN-1:0] misalign_addr_m,
`endif
    output logic            rd_write_m,
    output logic [1:0]      rd_write_src_m,
    output logic [4:0]      rd_m,
    output logic [XLEN-1:0] pc_m,
    output logic [XLEN-1:0] alu_res_m,
    output logic [XLEN-1:0] mem_read_data_m,
    output logic [XLEN-1:0] csr_data_m
);
    typedef enum logic {IDLE, WAIT} state_t;
    typedef struct packed {
        logic            valid;
        logic            rd_write;
        logic [1:0]      rd_write_src;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] alu_res;
        logic [XLEN-1:0] store_data;
        logic [XLEN-1:0] csr_data;
        logic            mem_read;
        logic            mem_write;
        logic [1:0]      mem_size;
        logic            mem_unsigned;
    } stage_t;

    state_t state_q, state_d;
    stage_t stage_q, stage_d;
    logic [1:0] a;
    logic is_byte, is_half, is_word, access, misalign, mem_op;
    logic [7:0] byte_lane;
    logic [15:0] half_lane;
    logic [XLEN-1:0] load_ext;

    assign a       = stage_q.alu_res[1:0];
    assign is_byte = stage_q.mem_size == 2'd0;
    assign is_half = stage_q.mem_size == 2'd1;
    assign is_word = stage_q.mem_size[1];
    assign access  = stage_q.valid & (stage_q.mem_read | stage_q.mem_write);
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign        = access & ((is_half & a[0]) | (is_word & |a));
    assign misalign_m      = misalign;
    assign misalign_addr_m = misalign ? stage_q.alu_res : '0;
`else
    assign misalign = 1'b0;
`endif
    assign mem_op = access & ~misalign;

    always_comb begin
        stage_d = stall_m ? stage_q : {valid_e, rd_write_e, rd_write_src_e, rd_e, pc_e, alu_res_e,
                                       store_data_e, csr_data_e, mem_read_e, mem_write_e,
                                       mem_size_e, mem_unsigned_e};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage_q <= '0;
        else        stage_q <= stage_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == IDLE) ? ((dmem_req && !dmem_ack) ? WAIT : IDLE)
                                    : (dmem_ack ? IDLE : WAIT);
    end

    // Stage registers hold while stalled, so a WAIT request keeps addr/be/wdata stable.
    always_comb begin
        dmem_req   = (state_q == WAIT) | mem_op;
        stall_m    = mem_op & ~dmem_ack;
        dmem_we    = mem_op & stage_q.mem_write;
        dmem_addr  = {stage_q.alu_res[XLEN-1:2], 2'b00};
        dmem_be    = !mem_op             ? 4'b0000 :
                     !stage_q.mem_write  ? 4'b1111 :
                     is_byte             ? 4'b0001 << a :
                     is_half             ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        dmem_wdata = is_byte ? {4{stage_q.store_data[7:0]}} :
                     is_half ? {2{stage_q.store_data[15:0]}} : stage_q.store_data;
    end

    always_comb begin
        byte_lane       = dmem_rdata[{a, 3'b000} +: 8];
        half_lane       = dmem_rdata[{a[1], 4'b0000} +: 16];
        load_ext        = is_byte ? {{24{~stage_q.mem_unsigned & byte_lane[7]}}, byte_lane} :
                          is_half ? {{16{~stage_q.mem_unsigned & half_lane[15]}}, half_lane} : dmem_rdata;
        mem_read_data_m = (stage_q.valid & stage_q.mem_read) ? load_ext : '0;
        rd_write_m      = stage_q.valid & stage_q.rd_write & ~stall_m & ~misalign;
        rd_write_src_m  = stage_q.rd_write_src;
        rd_m            = stage_q.rd;
        pc_m            = stage_q.pc;
        alu_res_m       = stage_q.alu_res;
        csr_data_m      = stage_q.csr_data;
    end
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: scoreboarded bench for the MEM stage handshake, alignment, stall and reset behaviour
module tb_memory_access;
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_t;
    typedef struct packed {
        logic [4:0]  rd;
        logic [1:0]  src;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] ld;
        logic [31:0] csr;
    } wb_t;

    logic clk, rst_n, valid_e, rd_write_e, mem_read_e, mem_write_e, mem_unsigned_e, dmem_ack;
    logic [1:0] rd_write_src_e, mem_size_e;
    logic [4:0] rd_e;
    logic [31:0] pc_e, alu_res_e, store_data_e, csr_data_e, dmem_rdata;
    logic stall_m, dmem_req, dmem_we, rd_write_m;
    logic [3:0] dmem_be;
    logic [1:0] rd_write_src_m;
    logic [4:0] rd_m;
    logic [31:0] dmem_addr, dmem_wdata, pc_m, alu_res_m, mem_read_data_m, csr_data_m;
`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_m;
    logic [31:0] misalign_addr_m;
`endif

    int checks = 0;
    int failures = 0;
    mem_t exp_mem[$], obs_mem[$];
    wb_t exp_wb[$], obs_wb[$];

    memory_access dut (
        .clk(clk), .rst_n(rst_n), .valid_e(valid_e), .rd_write_e(rd_write_e),
        .rd_write_src_e(rd_write_src_e), .rd_e(rd_e), .pc_e(pc_e), .alu_res_e(alu_res_e),
        .store_data_e(store_data_e), .csr_data_e(csr_data_e), .mem_read_e(mem_read_e),
        .mem_write_e(mem_write_e), .mem_size_e(mem_size_e), .mem_unsigned_e(mem_unsigned_e),
        .stall_m(stall_m), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_m(misalign_m), .misalign_addr_m(misalign_addr_m),
`endif
        .rd_write_m(rd_write_m), .rd_write_src_m(rd_write_src_m), .rd_m(rd_m), .pc_m(pc_m),
        .alu_res_m(alu_res_m), .mem_read_data_m(mem_read_data_m), .csr_data_m(csr_data_m)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] sd, input logic rdm, input logic wrm, input logic [1:0] sz,
                         input logic uns);
        valid_e = v; rd_write_e = rw; rd_e = rd; rd_write_src_e = rd[1:0];
        pc_e = alu ^ 32'h8000_0000; alu_res_e = alu; store_data_e = sd; csr_data_e = ~alu;
        mem_read_e = rdm; mem_write_e = wrm; mem_size_e = sz; mem_unsigned_e = uns;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    function automatic wb_t wb_exp(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] ld);
        return {rd, rd[1:0], alu ^ 32'h8000_0000, alu, ld, ~alu};
    endfunction

    task automatic at_pos();
        @(posedge clk);
        #1;
    endtask

    // Record every handshake and every writeback the DUT presents.
    task automatic at_neg();
        @(negedge clk);
        if (dmem_req && dmem_ack) obs_mem.push_back({dmem_we, dmem_addr, dmem_be, dmem_wdata});
        if (rd_write_m) obs_wb.push_back({rd_m, rd_write_src_m, pc_m, alu_res_m, mem_read_data_m, csr_data_m});
    endtask

    task automatic test_reset();
        rst_n = 0; dmem_ack = 0; dmem_rdata = 32'hFFFF_FFFF;
        drive(1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 2'd2, 1'b0);
        at_pos(); at_pos(); at_neg();
        checks++;
        if ({stall_m, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, rd_write_m, rd_write_src_m,
             rd_m, pc_m, alu_res_m, mem_read_data_m, csr_data_m} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: actual stall=%b req=%b be=%h rd_write=%b rd=%0d required all zero",
                     stall_m, dmem_req, dmem_be, rd_write_m, rd_m);
        end
`ifdef MEM_MISALIGN_TRAP_EN
        checks++;
        if ({misalign_m, misalign_addr_m} !== '0) begin
            failures++;
            $display("FAIL reset_misalign: actual=%b/%h required=0/0", misalign_m, misalign_addr_m);
        end
`endif
        idle(); dmem_rdata = 0; rst_n = 1;
        obs_mem.delete(); obs_wb.delete();
    endtask

    task automatic test_alu();
        mem_t em, om;
        wb_t ew, ow;
        drive(1'b1, 1'b1, 5'd5, 32'h1234, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
        exp_wb.push_back(wb_exp(5'd5, 32'h1234, 32'h0));
        at_pos(); idle(); at_neg();
        checks++;
        if ({rd_write_m, rd_m, stall_m, dmem_req} !== {1'b1, 5'd5, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL alu_op: actual rd_write=%b rd=%0d stall=%b req=%b required 1 5 0 0",
                     rd_write_m, rd_m, stall_m, dmem_req);
        end
        at_pos(); at_neg();
        while (exp_mem.size() + obs_mem.size() > 0) begin
            checks++;
            if (exp_mem.size() == 0 || obs_mem.size() == 0) begin
                failures++;
                $display("FAIL alu mem_count: actual=%0d required=%0d", obs_mem.size(), exp_mem.size());
                exp_mem.delete(); obs_mem.delete();
            end else begin
                em = exp_mem.pop_front(); om = obs_mem.pop_front();
                if (om !== em) begin failures++; $display("FAIL alu mem: actual=%h required=%h", om, em); end
            end
        end
        while (exp_wb.size() + obs_wb.size() > 0) begin
            checks++;
            if (exp_wb.size() == 0 || obs_wb.size() == 0) begin
                failures++;
                $display("FAIL alu wb_count: actual=%0d required=%0d", obs_wb.size(), exp_wb.size());
                exp_wb.delete(); obs_wb.delete();
            end else begin
                ew = exp_wb.pop_front(); ow = obs_wb.pop_front();
                if (ow !== ew) begin failures++; $display("FAIL alu wb: actual=%h required=%h", ow, ew); end
            end
        end
    endtask

    task automatic test_load();
        logic [31:0] la [8] = '{32'h103, 32'h103, 32'h100, 32'h102, 32'h102, 32'h100, 32'h104, 32'h101};
        logic [1:0]  ls [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0};
        logic        lu [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] lr [8] = '{32'h80FF_FF7F, 32'h80FF_FF7F, 32'h80FF_FF7F, 32'h8001_1234,
                                32'h8001_1234, 32'h8001_1234, 32'hDEAD_BEEF, 32'h1234_5678};
        logic [31:0] le [8] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_007F, 32'hFFFF_8001,
                                32'h0000_8001, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0000_0056};
        mem_t em, om;
        wb_t ew, ow;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 5'(i + 1), la[i], 32'h0, 1'b1, 1'b0, ls[i], lu[i]);
            exp_mem.push_back({1'b0, la[i] & 32'hFFFF_FFFC, 4'hF, 32'h0});
            exp_wb.push_back(wb_exp(5'(i + 1), la[i], le[i]));
            at_pos(); idle(); dmem_rdata = lr[i]; dmem_ack = 1;
            at_neg();
            checks++;
            if ({stall_m, dmem_req, dmem_we} !== 3'b010) begin
                failures++;
                $display("FAIL load_%0d ctrl: actual stall=%b req=%b we=%b required 0 1 0",
                         i, stall_m, dmem_req, dmem_we);
            end
            at_pos(); dmem_ack = 0;
        end
        at_neg();
        while (exp_mem.size() + obs_mem.size() > 0) begin
            checks++;
            if (exp_mem.size() == 0 || obs_mem.size() == 0) begin
                failures++;
                $display("FAIL load mem_count: actual=%0d required=%0d", obs_mem.size(), exp_mem.size());
                exp_mem.delete(); obs_mem.delete();
            end else begin
                em = exp_mem.pop_front(); om = obs_mem.pop_front();
                if (om !== em) begin failures++; $display("FAIL load mem: actual=%h required=%h", om, em); end
            end
        end
        while (exp_wb.size() + obs_wb.size() > 0) begin
            checks++;
            if (exp_wb.size() == 0 || obs_wb.size() == 0) begin
                failures++;
                $display("FAIL load wb_count: actual=%0d required=%0d", obs_wb.size(), exp_wb.size());
                exp_wb.delete(); obs_wb.delete();
            end else begin
                ew = exp_wb.pop_front(); ow = obs_wb.pop_front();
                if (ow !== ew) begin failures++; $display("FAIL load wb: actual=%h required=%h", ow, ew); end
            end
        end
    endtask

    task automatic test_store_wait();
        mem_t em, om;
        wb_t ew, ow;
        drive(1'b1, 1'b1, 5'd3, 32'h202, 32'hAAAA_BEEF, 1'b0, 1'b1, 2'd1, 1'b0);
        exp_mem.push_back({1'b1, 32'h200, 4'b1100, 32'hBEEF_BEEF});
        exp_wb.push_back(wb_exp(5'd3, 32'h202, 32'h0));
        at_pos();
        drive(1'b1, 1'b1, 5'd9, 32'h99, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
        exp_wb.push_back(wb_exp(5'd9, 32'h99, 32'h0));
        dmem_ack = 0; dmem_rdata = 32'h5555_5555;
        for (int k = 0; k < 3; k++) begin
            at_neg();
            checks++;
            if ({stall_m, dmem_req, rd_write_m, dmem_we, dmem_addr, dmem_be, dmem_wdata, alu_res_m} !==
                {1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 4'b1100, 32'hBEEF_BEEF, 32'h202}) begin
                failures++;
                $display("FAIL store_wait_%0d: actual stall=%b req=%b rdw=%b we=%b addr=%h be=%b wdata=%h alu=%h required 1 1 0 1 200 1100 beefbeef 202",
                         k, stall_m, dmem_req, rd_write_m, dmem_we, dmem_addr, dmem_be, dmem_wdata, alu_res_m);
            end
            at_pos();
        end
        dmem_ack = 1;
        at_neg();
        checks++;
        if ({stall_m, rd_write_m, dmem_req} !== 3'b011) begin
            failures++;
            $display("FAIL store_ack: actual stall=%b rdw=%b req=%b required 0 1 1", stall_m, rd_write_m, dmem_req);
        end
        at_pos(); dmem_ack = 0; idle();
        at_neg();
        checks++;
        if (dmem_req !== 1'b0) begin
            failures++;
            $display("FAIL store_after: actual req=%b required 0", dmem_req);
        end
        at_pos(); at_neg();
        while (exp_mem.size() + obs_mem.size() > 0) begin
            checks++;
            if (exp_mem.size() == 0 || obs_mem.size() == 0) begin
                failures++;
                $display("FAIL store mem_count: actual=%0d required=%0d", obs_mem.size(), exp_mem.size());
                exp_mem.delete(); obs_mem.delete();
            end else begin
                em = exp_mem.pop_front(); om = obs_mem.pop_front();
                if (om !== em) begin failures++; $display("FAIL store mem: actual=%h required=%h", om, em); end
            end
        end
        while (exp_wb.size() + obs_wb.size() > 0) begin
            checks++;
            if (exp_wb.size() == 0 || obs_wb.size() == 0) begin
                failures++;
                $display("FAIL store wb_count: actual=%0d required=%0d", obs_wb.size(), exp_wb.size());
                exp_wb.delete(); obs_wb.delete();
            end else begin
                ew = exp_wb.pop_front(); ow = obs_wb.pop_front();
                if (ow !== ew) begin failures++; $display("FAIL store wb: actual=%h required=%h", ow, ew); end
            end
        end
    endtask

    task automatic test_back_to_back();
        mem_t em, om;
        wb_t ew, ow;
        drive(1'b1, 1'b1, 5'd10, 32'h40, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
        exp_mem.push_back({1'b0, 32'h40, 4'hF, 32'h0});
        exp_wb.push_back(wb_exp(5'd10, 32'h40, 32'hCAFE_F00D));
        at_pos();
        drive(1'b1, 1'b0, 5'd0, 32'h55, 32'h1234_5678, 1'b0, 1'b1, 2'd0, 1'b0);
        exp_mem.push_back({1'b1, 32'h54, 4'b0010, 32'h7878_7878});
        dmem_ack = 1; dmem_rdata = 32'hCAFE_F00D;
        at_neg();
        checks++;
        if ({dmem_req, stall_m} !== 2'b10) begin
            failures++;
            $display("FAIL b2b_lw: actual req=%b stall=%b required 1 0", dmem_req, stall_m);
        end
        at_pos(); idle();
        at_neg();
        checks++;
        if ({dmem_req, dmem_we, rd_write_m, mem_read_data_m} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL b2b_sb: actual req=%b we=%b rdw=%b ld=%h required 1 1 0 0",
                     dmem_req, dmem_we, rd_write_m, mem_read_data_m);
        end
        at_pos(); dmem_ack = 0;
        at_neg();
        checks++;
        if (dmem_req !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle: actual req=%b required 0", dmem_req);
        end
        while (exp_mem.size() + obs_mem.size() > 0) begin
            checks++;
            if (exp_mem.size() == 0 || obs_mem.size() == 0) begin
                failures++;
                $display("FAIL b2b mem_count: actual=%0d required=%0d", obs_mem.size(), exp_mem.size());
                exp_mem.delete(); obs_mem.delete();
            end else begin
                em = exp_mem.pop_front(); om = obs_mem.pop_front();
                if (om !== em) begin failures++; $display("FAIL b2b mem: actual=%h required=%h", om, em); end
            end
        end
        while (exp_wb.size() + obs_wb.size() > 0) begin
            checks++;
            if (exp_wb.size() == 0 || obs_wb.size() == 0) begin
                failures++;
                $display("FAIL b2b wb_count: actual=%0d required=%0d", obs_wb.size(), exp_wb.size());
                exp_wb.delete(); obs_wb.delete();
            end else begin
                ew = exp_wb.pop_front(); ow = obs_wb.pop_front();
                if (ow !== ew) begin failures++; $display("FAIL b2b wb: actual=%h required=%h", ow, ew); end
            end
        end
    endtask

    task automatic test_reset_wait();
        mem_t em, om;
        wb_t ew, ow;
        drive(1'b1, 1'b1, 5'd4, 32'h80, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
        at_pos(); idle(); dmem_ack = 0;
        at_neg();
        checks++;
        if ({dmem_req, stall_m} !== 2'b11) begin
            failures++;
            $display("FAIL rstwait_pending: actual req=%b stall=%b required 1 1", dmem_req, stall_m);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({dmem_req, stall_m, rd_write_m} !== 3'b000) begin
            failures++;
            $display("FAIL rstwait_async: actual req=%b stall=%b rdw=%b required 0 0 0", dmem_req, stall_m, rd_write_m);
        end
        at_pos(); at_neg();
        rst_n = 1;
        drive(1'b1, 1'b1, 5'd12, 32'h1200, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
        exp_wb.push_back(wb_exp(5'd12, 32'h1200, 32'h0));
        at_pos(); idle();
        at_neg();
        checks++;
        if ({stall_m, dmem_req, rd_write_m} !== 3'b001) begin
            failures++;
            $display("FAIL rstwait_next: actual stall=%b req=%b rdw=%b required 0 0 1", stall_m, dmem_req, rd_write_m);
        end
        at_pos(); at_neg();
        while (exp_mem.size() + obs_mem.size() > 0) begin
            checks++;
            if (exp_mem.size() == 0 || obs_mem.size() == 0) begin
                failures++;
                $display("FAIL rstwait mem_count: actual=%0d required=%0d", obs_mem.size(), exp_mem.size());
                exp_mem.delete(); obs_mem.delete();
            end else begin
                em = exp_mem.pop_front(); om = obs_mem.pop_front();
                if (om !== em) begin failures++; $display("FAIL rstwait mem: actual=%h required=%h", om, em); end
            end
        end
        while (exp_wb.size() + obs_wb.size() > 0) begin
            checks++;
            if (exp_wb.size() == 0 || obs_wb.size() == 0) begin
                failures++;
                $display("FAIL rstwait wb_count: actual=%0d required=%0d", obs_wb.size(), exp_wb.size());
                exp_wb.delete(); obs_wb.delete();
            end else begin
                ew = exp_wb.pop_front(); ow = obs_wb.pop_front();
                if (ow !== ew) begin failures++; $display("FAIL rstwait wb: actual=%h required=%h", ow, ew); end
            end
        end
    endtask

`ifdef MEM_MISALIGN_TRAP_EN
    task automatic test_misalign();
        drive(1'b1, 1'b1, 5'd6, 32'h6, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
        at_pos(); idle();
        at_neg();
        checks++;
        if ({misalign_m, misalign_addr_m, dmem_req, stall_m, rd_write_m} !== {1'b1, 32'h6, 3'b000}) begin
            failures++;
            $display("FAIL misalign_lw: actual mis=%b addr=%h req=%b stall=%b rdw=%b required 1 6 0 0 0",
                     misalign_m, misalign_addr_m, dmem_req, stall_m, rd_write_m);
        end
        at_pos(); at_neg();
        checks++;
        if ({misalign_m, misalign_addr_m} !== '0) begin
            failures++;
            $display("FAIL misalign_clear: actual mis=%b addr=%h required 0 0", misalign_m, misalign_addr_m);
        end
        checks++;
        if (obs_mem.size() + obs_wb.size() != 0) begin
            failures++;
            $display("FAIL misalign_events: actual=%0d required=0", obs_mem.size() + obs_wb.size());
        end
        obs_mem.delete(); obs_wb.delete();
    endtask
`endif

    initial begin
        clk = 0; rst_n = 0; dmem_ack = 0; dmem_rdata = 0;
        idle();
        test_reset();
        test_alu();
        test_load();
        test_store_wait();
        test_back_to_back();
        test_reset_wait();
`ifdef MEM_MISALIGN_TRAP_EN
        test_misalign();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
